pc_sequencer: RTL and testbench

// Parametrised program-flow unit for the single-cycle CPU: owns the PC, the subroutine return stack and a

---
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-flow unit: PC register, return stack and a latched, prioritised, maskable interrupt controller.
// Optional build macro NESTED_IRQ_EN lets a lower-index interrupt preempt a running ISR.
module pc_sequencer #(
  parameter int              PC_W        = 10,
  parameter int              STACK_DEPTH = 8,
  parameter int              N_IRQ       = 3,
  parameter logic [PC_W-1:0] VEC_TOP     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_inc,
  input  logic             rel,
  input  logic             call,
  input  logic             ret,
  input  logic             reti,
  input  logic [PC_W-1:0]  target,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  output logic [PC_W-1:0]  pc,
  output logic             irq_ack,
  output logic [2:0]       irq_id,
  output logic             in_isr,
  output logic             stk_ovf,
  output logic             stk_unf
);
`ifdef NESTED_IRQ_EN
  localparam int ENT_W = PC_W + 4;
`else
  localparam int ENT_W = PC_W;
`endif
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [PC_W-1:0]  pcReg, pcNext, pcPlus1, pushPc;
  logic [ENT_W-1:0] stack [STACK_DEPTH];
  logic [ENT_W-1:0] pushData, popData;
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] topIdx;
  logic             push, pop, stkFull, stkEmpty;
  logic [N_IRQ-1:0] irqPrev, pending, ready, clrMask;
  logic [2:0]       acceptId;
  logic             accept, irqAllowed;

  assign pc       = pcReg;
  assign pcPlus1  = pcReg + PC_W'(1);
  assign stkFull  = (sp == SP_W'(STACK_DEPTH));
  assign stkEmpty = (sp == '0);
  assign topIdx   = sp[IDX_W-1:0] - IDX_W'(1);
  assign popData  = stack[topIdx];
  assign ready    = pending & ~irq_mask;

  // Lowest ready channel wins.
  always_comb begin
    acceptId = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (ready[i]) acceptId = 3'(i);
  end

`ifdef NESTED_IRQ_EN
  logic [3:0] level;  // active interrupt level, 4'hF = none
  assign irqAllowed = (level == 4'hF) || ({1'b0, acceptId} < level);
  assign in_isr     = (level != 4'hF);
  assign pushData   = {level, pushPc};
`else
  logic isrReg;
  assign irqAllowed = !isrReg;
  assign in_isr     = isrReg;
  assign pushData   = pushPc;
`endif
  assign accept = (|ready) && irqAllowed;

  // An accepted interrupt overrides every control input for this cycle.
  always_comb begin
    pcNext  = pcPlus1;
    push    = 1'b0;
    pop     = 1'b0;
    pushPc  = '0;
    clrMask = '0;
    if (accept) begin
      push    = 1'b1;
      pushPc  = pcReg;
      pcNext  = VEC_TOP - PC_W'(acceptId);
      clrMask = N_IRQ'(1) << acceptId;
    end else if (reti || ret) begin
      pop = 1'b1;
      if (!stkEmpty) pcNext = popData[PC_W-1:0];
    end else if (call) begin
      push   = 1'b1;
      pushPc = pcPlus1;
      pcNext = target;
    end else if (!s_inc) begin
      pcNext = target;
    end else if (rel) begin
      pcNext = pcReg + target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcReg   <= '0;
      sp      <= '0;
      irqPrev <= '0;
      pending <= '0;
      irq_ack <= 1'b0;
      irq_id  <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      pcReg   <= pcNext;
      irqPrev <= irq;
      // A new edge on the channel being accepted survives the clear.
      pending <= (pending & ~clrMask) | (irq & ~irqPrev);
      irq_ack <= accept;
      if (accept) irq_id <= acceptId;
      if (push) begin
        if (stkFull) stk_ovf <= 1'b1;
        else         sp <= sp + SP_W'(1);
      end
      if (pop) begin
        if (stkEmpty) stk_unf <= 1'b1;
        else          sp <= sp - SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !stkFull) stack[sp[IDX_W-1:0]] <= pushData;
  end

`ifdef NESTED_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       level <= 4'hF;
    else if (accept) level <= {1'b0, acceptId};
    else if (reti)   level <= stkEmpty ? 4'hF : popData[ENT_W-1:PC_W];
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       isrReg <= 1'b0;
    else if (accept) isrReg <= 1'b1;
    else if (reti)   isrReg <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (default build): vector table, corner sequences, random vs. model.
module tb_pc_sequencer;
  localparam int PC_W  = 10;
  localparam int DEPTH = 8;
  localparam int NI    = 3;
  localparam int MOD   = 1 << PC_W;

  logic            clk = 1'b0, reset = 1'b0;
  logic            s_inc = 1'b1, rel = 1'b0, call = 1'b0, ret = 1'b0, reti = 1'b0;
  logic [PC_W-1:0] target = '0;
  logic [NI-1:0]   irq = '0, irq_mask = '0;
  logic [PC_W-1:0] pc;
  logic            irq_ack, in_isr, stk_ovf, stk_unf;
  logic [2:0]      irq_id;

  int total = 0, bad = 0;

  pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .N_IRQ(NI)) dut (
    .clk(clk), .reset(reset), .s_inc(s_inc), .rel(rel), .call(call), .ret(ret), .reti(reti),
    .target(target), .irq(irq), .irq_mask(irq_mask), .pc(pc), .irq_ack(irq_ack),
    .irq_id(irq_id), .in_isr(in_isr), .stk_ovf(stk_ovf), .stk_unf(stk_unf));

  always #5 clk = ~clk;

  // Reference model: integer PC, queue as return stack.
  int          mPc, mId;
  int          mStk[$];
  bit [NI-1:0] mPend, mPrev;
  bit          mIsr, mAck, mOvf, mUnf;

  task automatic modelReset();
    mPc = 0; mStk.delete(); mPend = '0; mPrev = '0;
    mIsr = 0; mAck = 0; mOvf = 0; mUnf = 0; mId = 0;
  endtask

  task automatic mPush(int v);
    if (mStk.size() == DEPTH) mOvf = 1;
    else mStk.push_back(v);
  endtask

  task automatic modelStep();
    bit [NI-1:0] rdy, rise;
    rdy  = mPend & ~irq_mask;
    rise = irq & ~mPrev;
    mAck = 0;
    if (!mIsr && rdy != 0) begin
      mId = 0;
      while (!rdy[mId]) mId++;
      mPush(mPc);
      mPc = (MOD - 1) - mId;
      mIsr = 1; mAck = 1; mPend[mId] = 0;
    end else if (reti || ret) begin
      if (mStk.size() == 0) begin mUnf = 1; mPc = (mPc + 1) % MOD; end
      else mPc = mStk.pop_back();
      if (reti) mIsr = 0;
    end else if (call) begin
      mPush((mPc + 1) % MOD); mPc = int'(target);
    end else if (!s_inc) mPc = int'(target);
    else if (rel) mPc = (mPc + int'(target)) % MOD;
    else mPc = (mPc + 1) % MOD;
    mPend |= rise;
    mPrev = irq;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(bit si, bit rl, bit cl, bit rt, bit ri, int tg, bit [NI-1:0] iq, bit [NI-1:0] mk);
    s_inc = si; rel = rl; call = cl; ret = rt; reti = ri;
    target = PC_W'(tg); irq = iq; irq_mask = mk;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    reset = 1; s_inc = 1; rel = 0; call = 0; ret = 0; reti = 0; target = '0; irq = '0; irq_mask = '0;
    @(posedge clk); #1;
    reset = 0;
    modelReset();
    chk("rst.pc", pc, 0); chk("rst.ack", irq_ack, 0); chk("rst.isr", in_isr, 0);
    chk("rst.ovf", stk_ovf, 0); chk("rst.unf", stk_unf, 0);
  endtask

  task automatic chkModel(string tag);
    chk({tag, ".pc"}, pc, mPc);
    chk({tag, ".ack"}, irq_ack, mAck);
    if (mAck) chk({tag, ".id"}, irq_id, mId);
    chk({tag, ".isr"}, in_isr, mIsr);
    chk({tag, ".ovf"}, stk_ovf, mOvf);
    chk({tag, ".unf"}, stk_unf, mUnf);
  endtask

  typedef struct {
    bit sInc, rl, cl, rt, ri;
    int tgt;
    bit [NI-1:0] iq;
    int expPc;
    bit expAck;
    int expId;
    bit expIsr;
  } vec_t;
  vec_t tbl[15];

  initial begin
    //           sInc rl cl rt ri tgt     irq     pc      ack id isr
    tbl[0]  = '{1, 0, 0, 0, 0, 0,      3'b000, 'h001, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 'h3FE,  3'b000, 'h3FE, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0,      3'b000, 'h3FF, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0,      3'b000, 'h000, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 'h010,  3'b000, 'h010, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 0, 'h3FC,  3'b000, 'h00C, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 'h020,  3'b000, 'h020, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 0, 0, 'h100,  3'b000, 'h100, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 1, 0, 0,      3'b000, 'h021, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0,      3'b110, 'h022, 0, 0, 0};
    tbl[10] = '{1, 0, 1, 0, 0, 'h200,  3'b110, 'h3FE, 1, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 0,      3'b110, 'h3FF, 0, 0, 1};
    tbl[12] = '{1, 0, 0, 0, 1, 0,      3'b110, 'h022, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0,      3'b110, 'h3FD, 1, 2, 1};
    tbl[14] = '{1, 0, 0, 0, 1, 0,      3'b000, 'h022, 0, 0, 0};

    doReset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].sInc, tbl[i].rl, tbl[i].cl, tbl[i].rt, tbl[i].ri, tbl[i].tgt, tbl[i].iq, 3'b000);
      chk($sformatf("tbl%0d.pc", i), pc, tbl[i].expPc);
      chk($sformatf("tbl%0d.ack", i), irq_ack, tbl[i].expAck);
      if (tbl[i].expAck) chk($sformatf("tbl%0d.id", i), irq_id, tbl[i].expId);
      chk($sformatf("tbl%0d.isr", i), in_isr, tbl[i].expIsr);
      chk($sformatf("tbl%0d.flags", i), {stk_ovf, stk_unf}, 0);
    end

    // Stack overflow on the 9th call, then unwind to underflow.
    doReset();
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 1, 0, 0, 'h100 + i, 3'b000, 3'b000);
      chk($sformatf("call%0d.pc", i), pc, 'h100 + i);
      chk($sformatf("call%0d.ovf", i), stk_ovf, (i == 8) ? 1 : 0);
    end
    for (int r = 0; r < 8; r++) begin
      step(1, 0, 0, 1, 0, 0, 3'b000, 3'b000);
      chk($sformatf("ret%0d.pc", r), pc, (r < 7) ? ('h107 - r) : 1);
      chk($sformatf("ret%0d.unf", r), stk_unf, 0);
    end
    step(1, 0, 0, 1, 0, 0, 3'b000, 3'b000);
    chk("retEmpty.pc", pc, 2);
    chk("retEmpty.unf", stk_unf, 1);
    chk("retEmpty.ovf", stk_ovf, 1);

    // Masked channel stays pending until the mask drops.
    doReset();
    step(1, 0, 0, 0, 0, 0, 3'b001, 3'b001);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0, 0, 0, 3'b001, 3'b001);
      chk($sformatf("mask%0d.ack", k), irq_ack, 0);
    end
    step(1, 0, 0, 0, 0, 0, 3'b001, 3'b000);
    chk("unmask.pc", pc, 'h3FF); chk("unmask.ack", irq_ack, 1);
    chk("unmask.id", irq_id, 0); chk("unmask.isr", in_isr, 1);
    step(1, 0, 0, 0, 1, 0, 3'b001, 3'b000);
    chk("unmaskReti.pc", pc, 6); chk("unmaskReti.isr", in_isr, 0);

    // Asynchronous reset mid-cycle clears everything immediately.
    doReset();
    step(1, 0, 0, 1, 0, 0, 3'b000, 3'b000);
    step(0, 0, 0, 0, 0, 'h0A7, 3'b001, 3'b001);
    chk("pre.pc", pc, 'h0A7); chk("pre.unf", stk_unf, 1);
    #2 reset = 1;
    #1;
    chk("async.pc", pc, 0); chk("async.unf", stk_unf, 0);
    chk("async.ovf", stk_ovf, 0); chk("async.isr", in_isr, 0);
    irq = '0;
    #1 reset = 0;
    modelReset();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 0, 3'b000, 3'b000);
      chk($sformatf("post%0d.ack", k), irq_ack, 0);
    end
    chk("post.pc", pc, 3);

    // Random traffic against the reference model.
    doReset();
    for (int c = 0; c < 800; c++) begin
      bit [NI-1:0] iq, mk;
      bit si, rl, cl, rt, ri;
      int tg;
      if (c == 400) doReset();
      iq = irq; mk = irq_mask;
      for (int b = 0; b < NI; b++) if ($urandom_range(0, 5) == 0) iq[b] = ~iq[b];
      if ($urandom_range(0, 15) == 0) mk = NI'($urandom);
      si = ($urandom_range(0, 9) != 0);
      rl = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 7) == 0);
      rt = ($urandom_range(0, 11) == 0);
      ri = ($urandom_range(0, 9) == 0);
      tg = int'($urandom_range(0, MOD - 1));
      step(si, rl, cl, rt, ri, tg, iq, mk);
      chkModel($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
